// File: rtl/sram_req_arbiter_if.sv
// rtl/sram_req_arbiter_if.sv - SRAM-like request/response port bundle
// Carries one address phase (req/addr_ok plus fields) and one response phase
// (data_ok/rdata). The master drives the request; the slave answers it.
interface sram_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - IF/EXE requester arbiter for one SRAM-like port
// Data has priority unless inst has been refused STARVE_LIMIT cycles in a row.
// A grant that was offered downstream but not accepted is locked until accept,
// so the downstream sees stable fields. Each accepted request records its
// source in an in-order ID FIFO; responses are routed back by popping it.
module sram_req_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  sram_req_arbiter_if.slave      inst,
  sram_req_arbiter_if.slave      data,
  sram_req_arbiter_if.master     mem,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   proto_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_FREE      = 2'd0,
    ST_LOCK_INST = 2'd1,
    ST_LOCK_DATA = 2'd2
  } lock_e;

  lock_e            r_lock;
  lock_e            w_lock_nxt;

  logic             w_gnt_inst;
  logic             w_gnt_data;
  logic             w_mem_req;
  logic             w_accept;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_head_data;
  logic             w_starved;

  // ID FIFO: one bit per entry, 0 = inst, 1 = data
  logic [DEPTH-1:0] r_ids;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic [SW-1:0]    r_starve;
  logic             r_proto_err;

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_starved   = (r_starve == SW'(STARVE_LIMIT));
  assign w_pop       = mem.data_ok && !w_empty;
  assign w_head_data = r_ids[r_rptr];

  assign outstanding = r_count;
  assign proto_err   = r_proto_err;

  // Lock state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock <= ST_FREE;
    end else begin
      r_lock <= w_lock_nxt;
    end
  end

  // Grant selection, downstream request and next lock state
  always_comb begin
    w_gnt_inst = 1'b0;
    w_gnt_data = 1'b0;
    w_lock_nxt = r_lock;

    case (r_lock)
      ST_LOCK_INST: w_gnt_inst = 1'b1;
      ST_LOCK_DATA: w_gnt_data = 1'b1;
      default: begin
        if (data.req && !(inst.req && w_starved)) begin
          w_gnt_data = 1'b1;
        end else if (inst.req) begin
          w_gnt_inst = 1'b1;
        end
      end
    endcase

    // A full FIFO blocks the request outright, even if a pop is in flight
    w_mem_req = ((w_gnt_inst && inst.req) || (w_gnt_data && data.req)) && !w_full;
    w_accept  = w_mem_req && mem.addr_ok;

    // Hold the lock while blocked by a full FIFO; release only on accept
    if (w_accept) begin
      w_lock_nxt = ST_FREE;
    end else if (w_mem_req) begin
      w_lock_nxt = w_gnt_data ? ST_LOCK_DATA : ST_LOCK_INST;
    end
  end

  // Downstream request fields muxed from the granted source
  always_comb begin
    mem.req   = w_mem_req;
    mem.wr    = 1'b0;
    mem.size  = 2'd0;
    mem.wstrb = 4'd0;
    mem.addr  = 32'd0;
    mem.wdata = 32'd0;
    if (w_gnt_data) begin
      mem.wr    = data.wr;
      mem.size  = data.size;
      mem.wstrb = data.wstrb;
      mem.addr  = data.addr;
      mem.wdata = data.wdata;
    end else if (w_gnt_inst) begin
      mem.wr    = inst.wr;
      mem.size  = inst.size;
      mem.wstrb = inst.wstrb;
      mem.addr  = inst.addr;
      mem.wdata = inst.wdata;
    end
  end

  // Accept and response routing back to the requesters
  always_comb begin
    inst.addr_ok = w_accept && w_gnt_inst;
    data.addr_ok = w_accept && w_gnt_data;
    inst.data_ok = w_pop && !w_head_data;
    data.data_ok = w_pop && w_head_data;
    inst.rdata   = (w_pop && !w_head_data) ? mem.rdata : 32'd0;
    data.rdata   = (w_pop && w_head_data)  ? mem.rdata : 32'd0;
  end

  // ID FIFO: push on accept, pop on response; pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ids   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_ids[r_wptr] <= w_gnt_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= r_count + CW'(w_accept) - CW'(w_pop);
    end
  end

  // Count cycles inst is waiting while data holds the grant
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (!inst.req || (w_accept && w_gnt_inst)) begin
      r_starve <= '0;
    end else if (w_gnt_data && !w_starved) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // Sticky flag for a response with nothing outstanding
  always_ff @(posedge clk) begin
    if (reset) begin
      r_proto_err <= 1'b0;
    end else if (mem.data_ok && w_empty) begin
      r_proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - table-driven bench with response scoreboard
module tb_sram_req_arbiter;

  localparam logic [31:0] IA = 32'h1c00_0000;
  localparam logic [31:0] DA = 32'h8000_1000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] outstanding;
  logic       proto_err;

  sram_req_arbiter_if inst_bus();
  sram_req_arbiter_if data_bus();
  sram_req_arbiter_if mem_bus();

  sram_req_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .inst       (inst_bus),
    .data       (data_bus),
    .mem        (mem_bus),
    .outstanding(outstanding),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ir;
    logic        dr;
    logic        aok;
    logic        dok;
    logic [31:0] rd;
    logic        e_mreq;
    logic [31:0] e_maddr;
    logic        e_iaok;
    logic        e_daok;
    logic [2:0]  e_out;
    logic        e_perr;
  } vec_t;

  vec_t vecs[$];
  logic sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic ir, input logic dr, input logic aok, input logic dok,
                     input logic [31:0] rd, input logic mreq, input logic [31:0] maddr,
                     input logic iaok, input logic daok, input logic [2:0] out, input logic perr);
    vec_t v;
    v.ir = ir; v.dr = dr; v.aok = aok; v.dok = dok; v.rd = rd;
    v.e_mreq = mreq; v.e_maddr = maddr; v.e_iaok = iaok; v.e_daok = daok;
    v.e_out = out; v.e_perr = perr;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ir, input logic dr, input logic aok, input logic dok,
                       input logic [31:0] rd);
    inst_bus.req     = ir;
    data_bus.req     = dr;
    mem_bus.addr_ok  = aok;
    mem_bus.data_ok  = dok;
    mem_bus.rdata    = rd;
  endtask

  task automatic check_no_resp(input string tag);
    check({tag, " inst_data_ok"}, inst_bus.data_ok, 0);
    check({tag, " data_data_ok"}, data_bus.data_ok, 0);
    check({tag, " inst_rdata"},   inst_bus.rdata, 0);
    check({tag, " data_rdata"},   data_bus.rdata, 0);
  endtask

  initial begin
    logic src;
    string tag;

    inst_bus.wr = 1'b0; inst_bus.size = 2'd2; inst_bus.wstrb = 4'h0;
    inst_bus.addr = IA; inst_bus.wdata = 32'd0;
    data_bus.wr = 1'b1; data_bus.size = 2'd2; data_bus.wstrb = 4'hf;
    data_bus.addr = DA; data_bus.wdata = 32'hcafe_f00d;
    drive(0, 0, 0, 0, 0);

    // 1: inst only, zero-latency response
    add(1,0,1,0,0,                 1,IA,1,0,3'd0,0);
    add(0,0,0,1,32'h0280_0c0c,     0,0,0,0,3'd1,0);
    // 2: simultaneous requests, data first
    add(1,1,1,0,0,                 1,DA,0,1,3'd0,0);
    add(1,0,1,0,0,                 1,IA,1,0,3'd1,0);
    add(0,0,0,1,32'h1111_2222,     0,0,0,0,3'd2,0);
    add(0,0,0,1,32'h3333_4444,     0,0,0,0,3'd1,0);
    // 3: inst locked while addr_ok low, data arrives meanwhile
    add(1,0,0,0,0,                 1,IA,0,0,3'd0,0);
    add(1,1,0,0,0,                 1,IA,0,0,3'd0,0);
    add(1,1,0,0,0,                 1,IA,0,0,3'd0,0);
    add(1,1,1,0,0,                 1,IA,1,0,3'd0,0);
    add(0,1,1,1,32'h5555_6666,     1,DA,0,1,3'd1,0);
    add(0,0,0,1,32'h7777_8888,     0,0,0,0,3'd1,0);
    // 4: fill the FIFO, then a pop does not allow an accept in the same cycle
    for (int k = 0; k < 4; k++) add(0,1,1,0,0, 1,DA,0,1,3'(k),0);
    add(0,1,1,0,0,                 0,DA,0,0,3'd4,0);
    add(0,1,1,1,32'h9000_0000,     0,DA,0,0,3'd4,0);
    add(0,1,1,0,0,                 1,DA,0,1,3'd3,0);
    for (int k = 0; k < 4; k++) add(0,0,0,1,32'h9000_0001 + 32'(k), 0,0,0,0,3'(4-k),0);
    // 5: starvation: eight refused cycles, then inst forced, then data again
    add(1,1,1,0,0,                 1,DA,0,1,3'd0,0);
    for (int k = 0; k < 7; k++) add(1,1,1,1,32'ha000_0000 + 32'(k), 1,DA,0,1,3'd1,0);
    add(1,1,1,1,32'ha000_0007,     1,IA,1,0,3'd1,0);
    add(1,1,1,1,32'ha000_0008,     1,DA,0,1,3'd1,0);
    add(0,0,0,1,32'ha000_0009,     0,0,0,0,3'd1,0);
    // 6: response with empty FIFO
    add(0,0,0,1,32'hdead_0000,     0,0,0,0,3'd0,0);
    add(0,0,0,0,0,                 0,0,0,0,3'd0,1);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst mem_req", mem_bus.req, 0);
    check("rst mem_addr", mem_bus.addr, 0);
    check("rst inst_addr_ok", inst_bus.addr_ok, 0);
    check("rst data_addr_ok", data_bus.addr_ok, 0);
    check("rst outstanding", outstanding, 0);
    check("rst proto_err", proto_err, 0);
    check_no_resp("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ir, vecs[i].dr, vecs[i].aok, vecs[i].dok, vecs[i].rd);
      @(negedge clk);
      tag = $sformatf("v%0d", i);
      check({tag, " mem_req"}, mem_bus.req, vecs[i].e_mreq);
      check({tag, " mem_addr"}, mem_bus.addr, vecs[i].e_maddr);
      check({tag, " mem_wr"}, mem_bus.wr, vecs[i].e_maddr == DA);
      check({tag, " inst_addr_ok"}, inst_bus.addr_ok, vecs[i].e_iaok);
      check({tag, " data_addr_ok"}, data_bus.addr_ok, vecs[i].e_daok);
      check({tag, " outstanding"}, outstanding, vecs[i].e_out);
      check({tag, " proto_err"}, proto_err, vecs[i].e_perr);
      if (vecs[i].dok && sb_q.size() > 0) begin
        src = sb_q.pop_front();
        check({tag, " inst_data_ok"}, inst_bus.data_ok, !src);
        check({tag, " data_data_ok"}, data_bus.data_ok, src);
        check({tag, " inst_rdata"}, inst_bus.rdata, src ? 32'd0 : vecs[i].rd);
        check({tag, " data_rdata"}, data_bus.rdata, src ? vecs[i].rd : 32'd0);
      end else begin
        check_no_resp(tag);
      end
      if (vecs[i].e_iaok) sb_q.push_back(1'b0);
      if (vecs[i].e_daok) sb_q.push_back(1'b1);
      @(posedge clk); #1;
    end
    check("scoreboard drained", sb_q.size(), 0);

    // Reset mid-transaction discards the outstanding ID
    drive(1, 0, 1, 0, 0);
    @(negedge clk);
    check("mid inst_addr_ok", inst_bus.addr_ok, 1);
    check("mid outstanding pre", outstanding, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    check("mid outstanding held", outstanding, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid outstanding cleared", outstanding, 0);
    check("mid proto_err cleared", proto_err, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 32'hbeef_0001);
    @(negedge clk);
    check_no_resp("late");
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("late proto_err", proto_err, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("late proto_err sticky", proto_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
